// File: rtl/iso_sr_controller_pkg.sv
// Shared types and helpers for the isolator shift-register controller.
// Frame geometry, FSM states and the aovf serial-order unpack.
package iso_pkg;

  localparam int ISO_NUM_SLOTS  = 4;
  localparam int ISO_FRAME_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_GAP
  } iso_sr_state_t;

  typedef struct packed {
    logic [ISO_NUM_SLOTS-1:0] r;
    logic [ISO_NUM_SLOTS-1:0] l;
  } iso_aovf_t;

  // Serial order interleaves slots: bit 2n is left, 2n+1 is right.
  function automatic iso_aovf_t iso_unpack_aovf(
    input logic [ISO_FRAME_BITS-1:0] w
  );
    iso_aovf_t a;
    for (int n = 0; n < ISO_NUM_SLOTS; n++) begin
      a.l[n] = w[2*n];
      a.r[n] = w[2*n+1];
    end
    return a;
  endfunction

endpackage

// File: rtl/iso_sr_controller_if.sv
// Serial link between the controller and the isolator board chain.
// master = FPGA controller, slave = isolator serializer/deserializer.
interface iso_sr_if;

  logic mclk;
  logic srclk;
  logic dmcs;
  logic amcs;
  logic clksel;
  logic dirchan;
  logic aovf;

  modport master (
    output mclk, srclk, dmcs, amcs, clksel,
    input  dirchan, aovf
  );

  modport slave (
    input  mclk, srclk, dmcs, amcs, clksel,
    output dirchan, aovf
  );

endinterface

// File: rtl/iso_sr_controller_lane.sv
// One 8-bit shift lane: parallel load for the out path,
// MSB-first shift with serial fill for both out and in paths.
module iso_sr_lane
  import iso_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_i,
  input  logic                      shift_i,
  input  logic [ISO_FRAME_BITS-1:0] par_i,
  input  logic                      din_i,
  output logic                      dout_o,
  output logic [ISO_FRAME_BITS-1:0] q_o
);

  logic [ISO_FRAME_BITS-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= par_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[ISO_FRAME_BITS-2:0], din_i};
    end
  end

  assign dout_o = sr_q[ISO_FRAME_BITS-1];
  assign q_o    = sr_q;

endmodule

// File: rtl/iso_sr_controller.sv
// Free-running frame controller for the isolator 74xx shift chain.
// Define ISO_SR_STATUS_FILTER_EN to debounce slot_dir/slot_chan.
module iso_sr_controller
  import iso_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int FRAME_GAP = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ISO_NUM_SLOTS-1:0] dmcs_par,
  input  logic [ISO_NUM_SLOTS-1:0] amcs_par,
  input  logic [ISO_NUM_SLOTS-1:0] clksel_par,
  iso_sr_if.master                 iso,
  output logic [ISO_NUM_SLOTS-1:0] slot_dir,
  output logic [ISO_NUM_SLOTS-1:0] slot_chan,
  output logic [ISO_NUM_SLOTS-1:0] aovfl,
  output logic [ISO_NUM_SLOTS-1:0] aovfr,
  output logic                     cfg_applied,
  output logic                     status_valid
);

  localparam int PW = $clog2(2*CLK_DIV+1);
  localparam int GW = $clog2(FRAME_GAP+2);
  localparam int BW = $clog2(ISO_FRAME_BITS);
  localparam int NW = ISO_NUM_SLOTS;
  localparam int FW = ISO_FRAME_BITS;

  localparam logic [PW-1:0] PH_RISE  = PW'(CLK_DIV-1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2*CLK_DIV-1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((FRAME_GAP > 0) ? FRAME_GAP-1 : 0);
  localparam logic [BW-1:0] BIT_TOP  = BW'(FW-1);

  iso_sr_state_t state_q;
  logic [PW-1:0] ph_q;
  logic [BW-1:0] bit_q;
  logic [GW-1:0] gap_q;
  logic          mclk_q, srclk_q;
  logic          cfg_q, sv_q;
  logic [NW-1:0] dir_q, chan_q, aovfl_q, aovfr_q;

`ifdef ISO_SR_STATUS_FILTER_EN
  logic [FW-1:0] prev_q;
  logic          prev_vld_q;
`endif

  logic          load, tx_shift, rx_shift;
  logic [FW-1:0] rx_dc, rx_ov;
  logic [FW-1:0] dm_q_unused, am_q_unused, cs_q_unused;
  logic          dc_dout_unused, ov_dout_unused;
  logic          dm_s, am_s, cs_s;
  iso_aovf_t     ovf;

  assign load     = (state_q == ST_IDLE);
  assign tx_shift = (state_q == ST_SHIFT) && (ph_q == PH_LAST);
  // In-lanes sample on the cycle mclk rises, before the isolator shifts.
  assign rx_shift = (state_q == ST_SHIFT) && (ph_q == PH_RISE);
  assign ovf      = iso_unpack_aovf(rx_ov);

  iso_sr_lane u_dm (
    .clk(clk), .reset(reset), .load_i(load), .shift_i(tx_shift),
    .par_i({{(FW-NW){1'b0}}, dmcs_par}), .din_i(1'b0),
    .dout_o(dm_s), .q_o(dm_q_unused)
  );

  iso_sr_lane u_am (
    .clk(clk), .reset(reset), .load_i(load), .shift_i(tx_shift),
    .par_i({{(FW-NW){1'b0}}, amcs_par}), .din_i(1'b0),
    .dout_o(am_s), .q_o(am_q_unused)
  );

  iso_sr_lane u_cs (
    .clk(clk), .reset(reset), .load_i(load), .shift_i(tx_shift),
    .par_i({{(FW-NW){1'b0}}, clksel_par}), .din_i(1'b0),
    .dout_o(cs_s), .q_o(cs_q_unused)
  );

  iso_sr_lane u_dc (
    .clk(clk), .reset(reset), .load_i(1'b0), .shift_i(rx_shift),
    .par_i('0), .din_i(iso.dirchan),
    .dout_o(dc_dout_unused), .q_o(rx_dc)
  );

  iso_sr_lane u_ov (
    .clk(clk), .reset(reset), .load_i(1'b0), .shift_i(rx_shift),
    .par_i('0), .din_i(iso.aovf),
    .dout_o(ov_dout_unused), .q_o(rx_ov)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      mclk_q  <= 1'b0;
      srclk_q <= 1'b0;
      cfg_q   <= 1'b0;
      sv_q    <= 1'b0;
      dir_q   <= '0;
      chan_q  <= '0;
      aovfl_q <= '0;
      aovfr_q <= '0;
`ifdef ISO_SR_STATUS_FILTER_EN
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
`endif
    end else begin
      cfg_q <= 1'b0;
      sv_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          state_q <= ST_SHIFT;
          ph_q    <= '0;
          bit_q   <= BIT_TOP;
          mclk_q  <= 1'b0;
        end
        ST_SHIFT: begin
          if (ph_q == PH_RISE) mclk_q <= 1'b1;
          if (ph_q == PH_LAST) begin
            ph_q   <= '0;
            mclk_q <= 1'b0;
            if (bit_q == '0) begin
              state_q <= ST_LATCH;
              srclk_q <= 1'b1;
              cfg_q   <= 1'b1;
              aovfl_q <= ovf.l;
              aovfr_q <= ovf.r;
`ifdef ISO_SR_STATUS_FILTER_EN
              prev_q     <= rx_dc;
              prev_vld_q <= 1'b1;
              if (prev_vld_q && (prev_q == rx_dc)) begin
                chan_q <= rx_dc[FW-1:NW];
                dir_q  <= rx_dc[NW-1:0];
                sv_q   <= 1'b1;
              end
`else
              chan_q <= rx_dc[FW-1:NW];
              dir_q  <= rx_dc[NW-1:0];
              sv_q   <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q - BW'(1);
            end
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        ST_LATCH: begin
          if (ph_q == PH_RISE) srclk_q <= 1'b0;
          if (ph_q == PH_LAST) begin
            ph_q    <= '0;
            gap_q   <= '0;
            state_q <= (FRAME_GAP == 0) ? ST_IDLE : ST_GAP;
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) state_q <= ST_IDLE;
          else gap_q <= gap_q + GW'(1);
        end
      endcase
    end
  end

  assign iso.mclk     = mclk_q;
  assign iso.srclk    = srclk_q;
  assign iso.dmcs     = dm_s;
  assign iso.amcs     = am_s;
  assign iso.clksel   = cs_s;
  assign slot_dir     = dir_q;
  assign slot_chan    = chan_q;
  assign aovfl        = aovfl_q;
  assign aovfr        = aovfr_q;
  assign cfg_applied  = cfg_q;
  assign status_valid = sv_q;

endmodule

// File: tb/tb_iso_sr_controller.sv
// Self-checking bench for iso_sr_controller with a behavioural
// isolator board model (shift capture, latch, status serializer).
module tb_iso_sr_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dmcs_par, amcs_par, clksel_par;
  logic [3:0] slot_dir, slot_chan, aovfl, aovfr;
  logic       cfg_applied, status_valid;

  iso_sr_if iso ();

  iso_sr_controller #(.CLK_DIV(2), .FRAME_GAP(4)) dut (
    .clk(clk), .reset(reset),
    .dmcs_par(dmcs_par), .amcs_par(amcs_par), .clksel_par(clksel_par),
    .iso(iso),
    .slot_dir(slot_dir), .slot_chan(slot_chan),
    .aovfl(aovfl), .aovfr(aovfr),
    .cfg_applied(cfg_applied), .status_valid(status_valid)
  );

  always #5 clk = ~clk;

  // Isolator board model: never reset, keeps its latched config.
  logic [7:0] cap_d = '0, cap_a = '0, cap_c = '0;
  logic [7:0] lat_d = '0, lat_a = '0, lat_c = '0;
  logic [7:0] dc_sr = '0, ov_sr = '0;
  logic [7:0] dc_word = '0, ov_word = '0;
  logic [7:0] loaded_dc[$];
  logic [7:0] loaded_ov[$];
  int         srclk_cnt = 0;

  always @(posedge iso.mclk) begin
    cap_d <= {cap_d[6:0], iso.dmcs};
    cap_a <= {cap_a[6:0], iso.amcs};
    cap_c <= {cap_c[6:0], iso.clksel};
    dc_sr <= {dc_sr[6:0], 1'b0};
    ov_sr <= {ov_sr[6:0], 1'b0};
  end

  always @(posedge iso.srclk) begin
    lat_d <= cap_d;
    lat_a <= cap_a;
    lat_c <= cap_c;
    dc_sr <= dc_word;
    ov_sr <= ov_word;
    loaded_dc.push_back(dc_word);
    loaded_ov.push_back(ov_word);
    srclk_cnt++;
  end

  assign iso.dirchan = dc_sr[7];
  assign iso.aovf    = ov_sr[7];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_pulse(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cfg_applied && cyc < 200);
    if (!cfg_applied) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cfg_timeout: got no pulse within %0d cycles", cyc);
    end
  endtask

  // Reference unpack: {l, r} from the isolator's interleaved order.
  function automatic logic [7:0] ref_lr(input logic [7:0] w);
    logic [3:0] l, r;
    for (int n = 0; n < 4; n++) begin
      l[n] = w[2*n];
      r[n] = w[2*n+1];
    end
    return {l, r};
  endfunction

  function automatic logic [23:0] cfg_word(input logic [3:0] d,
                                           input logic [3:0] a,
                                           input logic [3:0] c);
    return {4'h0, d, 4'h0, a, 4'h0, c};
  endfunction

  typedef struct packed {
    logic [3:0] dm, am, cs;
    logic [7:0] dc, ov;
    logic [3:0] e_chan, e_dir, e_l, e_r;
  } vec_t;

  vec_t tbl[4];

  logic [31:0] outs_all;
  logic [7:0]  exp_dc, rx, prv, rxo;
  logic        upd;
  logic [3:0]  pd, pa, pc;
  int          c, sr0;

  assign outs_all = {iso.mclk, iso.srclk, iso.dmcs, iso.amcs,
                     iso.clksel, cfg_applied, status_valid,
                     slot_chan, slot_dir, aovfl, aovfr};

  initial begin
    tbl[0] = '{dm:4'h2, am:4'h0, cs:4'h1, dc:8'h22, ov:8'h00,
               e_chan:4'h2, e_dir:4'h2, e_l:4'h0, e_r:4'h0};
    tbl[1] = '{dm:4'hF, am:4'h5, cs:4'hA, dc:8'h81, ov:8'h81,
               e_chan:4'h8, e_dir:4'h1, e_l:4'h1, e_r:4'h8};
    tbl[2] = '{dm:4'h0, am:4'hF, cs:4'h0, dc:8'h3C, ov:8'hAA,
               e_chan:4'h3, e_dir:4'hC, e_l:4'h0, e_r:4'hF};
    tbl[3] = '{dm:4'h9, am:4'h6, cs:4'hF, dc:8'hF0, ov:8'h5A,
               e_chan:4'hF, e_dir:4'h0, e_l:4'hC, e_r:4'h3};

    reset      = 1'b0;
    dmcs_par   = 4'b0010;
    amcs_par   = 4'b0000;
    clksel_par = 4'b0001;
    dc_word    = 8'h22;
    ov_word    = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_all, 32'h0);

    reset = 1'b1;
    wait_pulse(c);
    chk("first_latency", c, 33);
    chk("first_cfg", {lat_d, lat_a, lat_c}, 24'h020001);
    chk("stale_status", {slot_chan, slot_dir}, 8'h00);
    wait_pulse(c);
    chk("frame_period", c, 41);
`ifdef ISO_SR_STATUS_FILTER_EN
    chk("second_status", {slot_chan, slot_dir, 3'b0, status_valid},
        {8'h00, 4'h0});
`else
    chk("second_status", {slot_chan, slot_dir, 3'b0, status_valid},
        {8'h22, 4'h1});
`endif

    // Table vectors: three frames let config and filtered status settle.
    for (int i = 0; i < 4; i++) begin
      dmcs_par   = tbl[i].dm;
      amcs_par   = tbl[i].am;
      clksel_par = tbl[i].cs;
      dc_word    = tbl[i].dc;
      ov_word    = tbl[i].ov;
      repeat (3) wait_pulse(c);
      chk($sformatf("tbl%0d_cfg", i), {lat_d, lat_a, lat_c},
          cfg_word(tbl[i].dm, tbl[i].am, tbl[i].cs));
      chk($sformatf("tbl%0d_status", i),
          {slot_chan, slot_dir, aovfl, aovfr},
          {tbl[i].e_chan, tbl[i].e_dir, tbl[i].e_l, tbl[i].e_r});
      chk($sformatf("tbl%0d_valid", i), status_valid, 1);
    end

    // amcs_par change mid-SHIFT must wait for the next snapshot.
    amcs_par = 4'h0;
    repeat (15) @(negedge clk);
    amcs_par = 4'hF;
    wait_pulse(c);
    chk("amcs_midframe", lat_a, 8'h00);
    wait_pulse(c);
    chk("amcs_nextframe", lat_a, 8'h0F);

    // One-frame dirchan glitch.
    dc_word = 8'h22;
    ov_word = 8'h00;
    repeat (3) wait_pulse(c);
    dc_word = 8'hFF;
    wait_pulse(c);
    dc_word = 8'h22;
    wait_pulse(c);
`ifdef ISO_SR_STATUS_FILTER_EN
    chk("glitch_rx", {slot_chan, slot_dir, 3'b0, status_valid},
        {8'h22, 4'h0});
    wait_pulse(c);
    chk("glitch_after", {slot_chan, slot_dir, 3'b0, status_valid},
        {8'h22, 4'h0});
`else
    chk("glitch_rx", {slot_chan, slot_dir, 3'b0, status_valid},
        {8'hFF, 4'h1});
    wait_pulse(c);
    chk("glitch_after", {slot_chan, slot_dir, 3'b0, status_valid},
        {8'h22, 4'h1});
`endif

    // Randomised frames against the frame-level reference.
    exp_dc = 8'h22;
    for (int j = 0; j < 30; j++) begin
      pd = 4'($urandom);
      pa = 4'($urandom);
      pc = 4'($urandom);
      dmcs_par   = pd;
      amcs_par   = pa;
      clksel_par = pc;
      if ($urandom_range(0, 2) != 0) dc_word = 8'($urandom);
      ov_word = 8'($urandom);
      wait_pulse(c);
      chk($sformatf("rnd%0d_period", j), c, 41);
      chk($sformatf("rnd%0d_cfg", j), {lat_d, lat_a, lat_c},
          cfg_word(pd, pa, pc));
      rx  = loaded_dc[loaded_dc.size()-2];
      prv = loaded_dc[loaded_dc.size()-3];
      rxo = loaded_ov[loaded_ov.size()-2];
`ifdef ISO_SR_STATUS_FILTER_EN
      upd = (rx == prv);
`else
      upd = 1'b1;
      prv = rx;
`endif
      if (upd) exp_dc = rx;
      chk($sformatf("rnd%0d_status", j),
          {slot_chan, slot_dir, aovfl, aovfr, 7'b0, status_valid},
          {exp_dc, ref_lr(rxo), 7'b0, upd});
    end

    // Reset in SHIFT bit 4: outputs clear, no latch edge, clean restart.
    dmcs_par   = 4'hA;
    amcs_par   = 4'h5;
    clksel_par = 4'h3;
    wait_pulse(c);
    chk("pre_reset_cfg", {lat_d, lat_a, lat_c}, cfg_word(4'hA, 4'h5, 4'h3));
    repeat (22) @(negedge clk);
    sr0   = srclk_cnt;
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", outs_all, 32'h0);
    dmcs_par   = 4'h6;
    amcs_par   = 4'h9;
    clksel_par = 4'hC;
    repeat (5) @(negedge clk);
    chk("midreset_no_srclk", srclk_cnt - sr0, 0);
    chk("midreset_cfg_kept", {lat_d, lat_a, lat_c},
        cfg_word(4'hA, 4'h5, 4'h3));
    reset = 1'b1;
    wait_pulse(c);
    chk("restart_latency", c, 33);
    chk("restart_cfg", {lat_d, lat_a, lat_c}, cfg_word(4'h6, 4'h9, 4'hC));
    wait_pulse(c);
    chk("restart_period", c, 41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
